// File: rtl/stereo_matrix_decoder_if.sv
// Sample bus between the stereo matrix decoder and its neighbours: the
// scaled sum/difference samples and gains going in, the rebuilt left/right
// samples and the status strobes coming out.
interface stereo_matrix_decoder_if #(
  parameter int W  = 18,
  parameter int GW = 4
);
  logic signed [W-1:0]  LpR;
  logic signed [W-1:0]  LmR;
  logic        [GW-1:0] Gs;
  logic        [GW-1:0] Gd;
  logic                 clken_48;
  logic signed [W-1:0]  LEFT;
  logic signed [W-1:0]  RIGHT;
  logic                 valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output LpR, LmR, Gs, Gd, clken_48,
    input  LEFT, RIGHT, valid, busy, overrun
  );

  modport slave (
    input  LpR, LmR, Gs, Gd, clken_48,
    output LEFT, RIGHT, valid, busy, overrun
  );
endinterface

// File: rtl/stereo_matrix_decoder.sv
// Stereo matrix decoder: rebuilds LEFT/RIGHT from gain-scaled L+R and L-R
// samples. A single shift-add multiplier walks the gain bits LSB first, first
// for the sum channel and then for the difference channel, and a final cycle
// forms the saturated sum and difference.
module stereo_matrix_decoder #(
  parameter int W   = 18,
  parameter int GW  = 4,
  parameter int GSH = 2
) (
  input  logic clock,
  input  logic reset,
  stereo_matrix_decoder_if.slave bus
);

  localparam int AW = W + GW;
  localparam int SW = AW - GSH;
  localparam int LW = SW + 1;
  localparam int CW = (GW > 1) ? $clog2(GW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(GW - 1);

  typedef enum logic [1:0] {IDLE, MUL_S, MUL_D, SUM} state_t;

  state_t               state;
  logic signed [W-1:0]  lpr_q;
  logic signed [W-1:0]  lmr_q;
  logic        [GW-1:0] gs_q;
  logic        [GW-1:0] gd_q;
  logic signed [AW-1:0] acc;
  logic        [CW-1:0] bit_cnt;
  logic signed [SW-1:0] s_q;
  logic signed [SW-1:0] d_q;
  logic signed [W-1:0]  left_q;
  logic signed [W-1:0]  right_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 overrun_q;

  logic signed [W-1:0]  mul_op;
  logic                 gain_bit;
  logic signed [AW-1:0] partial;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] acc_shr;
  logic signed [LW-1:0] sum_lr;
  logic signed [LW-1:0] diff_lr;
  logic signed [W-1:0]  left_sat;
  logic signed [W-1:0]  right_sat;

  // Clamp a wide signed value into the W-bit output range.
  function automatic logic signed [W-1:0] saturate(input logic signed [LW-1:0] x);
    if (x[LW-1:W-1] == {(LW-W+1){x[LW-1]}})
      return x[W-1:0];
    else if (x[LW-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  // Shared shift-add step: the operand and gain bit come from whichever channel is being multiplied.
  always_comb begin
    mul_op   = lpr_q;
    gain_bit = gs_q[bit_cnt];
    if (state == MUL_D) begin
      mul_op   = lmr_q;
      gain_bit = gd_q[bit_cnt];
    end
    partial  = {{GW{mul_op[W-1]}}, mul_op} <<< bit_cnt;
    acc_next = gain_bit ? (acc + partial) : acc;
    acc_shr  = acc_next >>> GSH;
  end

  // Output stage: widen S and D by one bit so the sum and difference cannot wrap before clamping.
  always_comb begin
    sum_lr    = {s_q[SW-1], s_q} + {d_q[SW-1], d_q};
    diff_lr   = {s_q[SW-1], s_q} - {d_q[SW-1], d_q};
    left_sat  = saturate(sum_lr);
    right_sat = saturate(diff_lr);
  end

  // Conversion sequencer with registered outputs; strobes outside IDLE are only flagged as overruns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lpr_q     <= '0;
      lmr_q     <= '0;
      gs_q      <= '0;
      gd_q      <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      s_q       <= '0;
      d_q       <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= bus.clken_48 && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.clken_48) begin
            lpr_q   <= bus.LpR;
            lmr_q   <= bus.LmR;
            gs_q    <= bus.Gs;
            gd_q    <= bus.Gd;
            acc     <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= MUL_S;
          end
        end
        MUL_S: begin
          if (bit_cnt == LAST_BIT) begin
            s_q     <= acc_shr[SW-1:0];
            acc     <= '0;
            bit_cnt <= '0;
            state   <= MUL_D;
          end else begin
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        MUL_D: begin
          if (bit_cnt == LAST_BIT) begin
            d_q     <= acc_shr[SW-1:0];
            acc     <= '0;
            bit_cnt <= '0;
            state   <= SUM;
          end else begin
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        SUM: begin
          left_q  <= left_sat;
          right_q <= right_sat;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.LEFT    = left_q;
  assign bus.RIGHT   = right_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_stereo_matrix_decoder.sv
// Directed bench for stereo_matrix_decoder: each scenario task drives one or
// more conversions and compares the outputs against hand-computed values.
module tb_stereo_matrix_decoder;
  localparam int W   = 18;
  localparam int GW  = 4;
  localparam int GSH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  stereo_matrix_decoder_if #(.W(W), .GW(GW)) bus();

  stereo_matrix_decoder #(.W(W), .GW(GW), .GSH(GSH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz-style free-running system clock.
  always #5 clock = ~clock;

  // Start one conversion and follow it to its valid pulse (bounded). Inputs are
  // scrambled after capture; extra_at > 0 places a second strobe at that edge.
  task automatic apply_stimulus(input logic signed [W-1:0] lpr, input logic signed [W-1:0] lmr,
                                input logic [GW-1:0] gs, input logic [GW-1:0] gd,
                                input int extra_at,
                                output int latency, output int busy_n, output int ovr_n);
    @(negedge clock);
    bus.LpR = lpr;
    bus.LmR = lmr;
    bus.Gs = gs;
    bus.Gd = gd;
    bus.clken_48 = 1'b1;
    @(posedge clock);
    #1;
    bus.LpR = lpr ^ 18'h15a5a;
    bus.LmR = lmr ^ 18'h0c3c3;
    bus.Gs = ~gs;
    bus.Gd = ~gd;
    latency = 0;
    ovr_n = 0;
    busy_n = bus.busy ? 1 : 0;
    bus.clken_48 = (extra_at == 1);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      #1;
      if (bus.overrun) ovr_n++;
      bus.clken_48 = (n == extra_at - 1);
      if (bus.valid) begin
        latency = n;
        break;
      end
      if (bus.busy) busy_n++;
    end
    bus.clken_48 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.LEFT !== 18'sd0 || bus.RIGHT !== 18'sd0) begin
      errors++;
      $display("[TB] FAIL reset_lr: got L=%0d R=%0d expected 0/0", bus.LEFT, bus.RIGHT);
    end
    checks++;
    if ({bus.valid, bus.busy, bus.overrun} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.valid, bus.busy, bus.overrun});
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (bus.LEFT !== 18'sd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset: got L=%0d busy=%b expected 0/0", bus.LEFT, bus.busy);
    end
  endtask

  task automatic test_unity();
    int lat, bn, on;
    apply_stimulus(18'sd1000, 18'sd200, 4'd4, 4'd4, 0, lat, bn, on);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("[TB] FAIL unity_latency: got %0d expected 9", lat);
    end
    checks++;
    if (bus.LEFT !== 18'sd1200 || bus.RIGHT !== 18'sd800) begin
      errors++;
      $display("[TB] FAIL unity_lr: got L=%0d R=%0d expected 1200/800", bus.LEFT, bus.RIGHT);
    end
    checks++;
    if (bn !== 9 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unity_busy: got %0d cycles (busy now %b) expected 9 (0)", bn, bus.busy);
    end
    checks++;
    if (on !== 0) begin
      errors++;
      $display("[TB] FAIL unity_overrun: got %0d expected 0", on);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.LEFT !== 18'sd1200 || bus.RIGHT !== 18'sd800 || bus.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unity_hold: got L=%0d R=%0d v=%b expected 1200/800/0", bus.LEFT, bus.RIGHT, bus.valid);
    end
  endtask

  task automatic test_saturation();
    int lat, bn, on;
    apply_stimulus(18'sd100000, 18'sd50000, 4'd8, 4'd8, 0, lat, bn, on);
    checks++;
    if (lat !== 9 || bus.LEFT !== 18'sd131071 || bus.RIGHT !== 18'sd100000) begin
      errors++;
      $display("[TB] FAIL sat_pos: got lat=%0d L=%0d R=%0d expected 9/131071/100000", lat, bus.LEFT, bus.RIGHT);
    end
    apply_stimulus(-18'sd131072, 18'sd1, 4'd4, 4'd4, 0, lat, bn, on);
    checks++;
    if (lat !== 9 || bus.LEFT !== -18'sd131071 || bus.RIGHT !== -18'sd131072) begin
      errors++;
      $display("[TB] FAIL sat_neg: got lat=%0d L=%0d R=%0d expected 9/-131071/-131072", lat, bus.LEFT, bus.RIGHT);
    end
  endtask

  task automatic test_gain_edges();
    int lat, bn, on;
    apply_stimulus(18'sd5000, -18'sd7, 4'd0, 4'd3, 0, lat, bn, on);
    checks++;
    if (lat !== 9 || bus.LEFT !== -18'sd6 || bus.RIGHT !== 18'sd6) begin
      errors++;
      $display("[TB] FAIL gain_zero_floor: got lat=%0d L=%0d R=%0d expected 9/-6/6", lat, bus.LEFT, bus.RIGHT);
    end
    apply_stimulus(18'sd1000, 18'sd300, 4'd15, 4'd0, 0, lat, bn, on);
    checks++;
    if (lat !== 9 || bus.LEFT !== 18'sd3750 || bus.RIGHT !== 18'sd3750) begin
      errors++;
      $display("[TB] FAIL gain_max: got lat=%0d L=%0d R=%0d expected 9/3750/3750", lat, bus.LEFT, bus.RIGHT);
    end
  endtask

  task automatic test_overrun();
    int lat, bn, on;
    apply_stimulus(18'sd300, 18'sd100, 4'd4, 4'd4, 3, lat, bn, on);
    checks++;
    if (on !== 1) begin
      errors++;
      $display("[TB] FAIL overrun_count: got %0d expected 1", on);
    end
    checks++;
    if (lat !== 9 || bus.LEFT !== 18'sd400 || bus.RIGHT !== 18'sd200) begin
      errors++;
      $display("[TB] FAIL overrun_result: got lat=%0d L=%0d R=%0d expected 9/400/200", lat, bus.LEFT, bus.RIGHT);
    end
    apply_stimulus(-18'sd50, 18'sd25, 4'd4, 4'd4, 0, lat, bn, on);
    checks++;
    if (lat !== 9 || on !== 0 || bus.LEFT !== -18'sd25 || bus.RIGHT !== -18'sd75) begin
      errors++;
      $display("[TB] FAIL after_overrun: got lat=%0d ovr=%0d L=%0d R=%0d expected 9/0/-25/-75", lat, on, bus.LEFT, bus.RIGHT);
    end
  endtask

  task automatic test_overrun_at_valid();
    int lat, bn, on;
    int late_valid;
    apply_stimulus(18'sd40, 18'sd20, 4'd4, 4'd4, 9, lat, bn, on);
    checks++;
    if (on !== 1 || lat !== 9 || bus.LEFT !== 18'sd60 || bus.RIGHT !== 18'sd20) begin
      errors++;
      $display("[TB] FAIL overrun_sum: got ovr=%0d lat=%0d L=%0d R=%0d expected 1/9/60/20", on, lat, bus.LEFT, bus.RIGHT);
    end
    late_valid = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clock);
      #1;
      if (bus.valid || bus.busy) late_valid++;
    end
    checks++;
    if (late_valid !== 0) begin
      errors++;
      $display("[TB] FAIL overrun_sum_ignored: got %0d active cycles expected 0", late_valid);
    end
  endtask

  task automatic test_reset_mid_conversion();
    int lat, bn, on;
    int seen;
    apply_stimulus(18'sd1000, 18'sd200, 4'd4, 4'd4, 0, lat, bn, on);
    checks++;
    if (bus.LEFT !== 18'sd1200) begin
      errors++;
      $display("[TB] FAIL pre_abort: got L=%0d expected 1200", bus.LEFT);
    end
    @(negedge clock);
    bus.LpR = 18'sd7000;
    bus.LmR = 18'sd3000;
    bus.clken_48 = 1'b1;
    @(posedge clock);
    #1;
    bus.clken_48 = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.LEFT !== 18'sd0 || bus.RIGHT !== 18'sd0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: got L=%0d R=%0d busy=%b v=%b expected 0/0/0/0", bus.LEFT, bus.RIGHT, bus.busy, bus.valid);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clock);
      #1;
      if (bus.valid) seen++;
    end
    checks++;
    if (seen !== 0 || bus.LEFT !== 18'sd0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid: got %0d pulses L=%0d expected 0/0", seen, bus.LEFT);
    end
    apply_stimulus(18'sd500, -18'sd100, 4'd4, 4'd4, 0, lat, bn, on);
    checks++;
    if (lat !== 9 || bus.LEFT !== 18'sd400 || bus.RIGHT !== 18'sd600) begin
      errors++;
      $display("[TB] FAIL abort_recover: got lat=%0d L=%0d R=%0d expected 9/400/600", lat, bus.LEFT, bus.RIGHT);
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    bus.LpR = '0;
    bus.LmR = '0;
    bus.Gs = '0;
    bus.Gd = '0;
    bus.clken_48 = 1'b0;
    test_reset();
    test_unity();
    test_saturation();
    test_gain_edges();
    test_overrun();
    test_overrun_at_valid();
    test_reset_mid_conversion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
